siso_frame_rx: RTL and testbench
================================

Name: siso_frame_rx

Overview:
- Serial frame receiver that consumes the 1-bit stream produced by the team's SISO shift-register chain and rebuilds parallel words.
- Detects a start bit, shifts in W data bits MSB-first, optionally checks parity, and checks the stop bit.
- Presents each word on a valid/ready output holding register for the downstream parallel consumer.

Parameters:
- W, 8, data bits per frame (legal range 2..32).
- CNT_W, $clog2(W+1), width of the bit counter (derived; do not override).

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- si  input  1  serial data; idle level 1.
- bit_en  input  1  sample strobe; si is sampled only on edges where bit_en=1.
- dout  output  W  received word, first-received bit in dout[W-1].
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid&dout_ready.
- busy  output  1  1 in any state other than IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: completed word dropped because the holding register was full.
- parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 without the optional feature).

Behaviour:
- Reset, sampled on posedge clk while reset=1:
  - state=IDLE; shift register and counter cleared.
  - dout=0, dout_valid=0, busy=0, all pulse outputs 0.
  - Reset mid-frame abandons the frame with no error pulse.
  - Reset overrides every simultaneous event.
- FSM states: IDLE, DATA, PAR, STOP. Transitions occur only on bit_en=1 edges; with bit_en=0 the FSM, shift register and counter hold.
- IDLE: si=0 -> DATA with cnt=0. si=1 -> stay in IDLE.
- DATA:
  - Each bit_en edge: shreg <= {shreg[W-2:0], si}, cnt <= cnt+1.
  - When cnt==W-1 after shifting -> PAR if the feature is enabled, else STOP.
- PAR: sample the parity bit -> STOP.
- STOP, on the sampling edge, go to IDLE and:
  - si=1: the frame is good; commit.
  - si=0: pulse frame_err, discard the word, no commit. A new start bit is searched for from the next bit_en.
- Commit, registered on the same edge as the stop sample:
  - The holding register is free if dout_valid=0, or if dout_valid&dout_ready on this edge.
  - If free: dout <= shreg, dout_valid <= 1.
  - Otherwise: the word is dropped, overrun pulses, and dout/dout_valid are unchanged.
- Latency: dout_valid rises the cycle after the edge that samples a good stop bit.
- Handshake:
  - dout_valid clears after a dout_valid&dout_ready edge unless a commit happens on that same edge. A same-edge commit wins: dout takes the new word and dout_valid stays 1.
  - dout stays stable while dout_valid=1 and dout_ready=0.
- Pulses last exactly one clk, on the cycle after the causing edge.
- Minimum frame length: 1 start + W data (+1 parity) + 1 stop bit_en samples. A start bit may directly follow a stop bit.

Optional Feature:
- Macro SISO_RX_PARITY_EN.
- Defined:
  - PAR state exists; the expected parity bit is the even parity over the W data bits (^data).
  - A mismatch pulses parity_err at the stop edge.
  - The word still commits if the stop bit is good.
  - If frame_err and parity_err are both due on the same frame, both pulse.
- Undefined:
  - No PAR state; the frame is 1+W+1 samples.
  - parity_err is tied 0.

Decomposition:
- Package siso_rx_pkg:
  - state enum rx_state_t {IDLE, DATA, PAR, STOP}.
  - Constants IDLE_LEVEL=1'b1, START_LEVEL=1'b0.
- Sub-module siso_rx_hold: the output holding register.
  - Contains dout/dout_valid, the commit/accept logic and overrun generation.
  - Inputs: commit, word, dout_ready.
- The FSM, shift register and counter live in siso_frame_rx.

Test Plan:
- Basic frame, W=8, bit_en=1 every clk, dout_ready=1.
  - Stimulus: serial 0,1,0,1,0,0,1,0,1,1 (start, data 0xA5, stop).
  - Response: dout=0xA5 with dout_valid=1 for one cycle, the cycle after the stop edge; no error pulses.
- Framing error.
  - Stimulus: frame 0x3C with stop bit 0.
  - Response: one frame_err pulse, dout_valid stays 0; the next good frame 0x81 is received correctly.
- Backpressure and overrun.
  - Stimulus: dout_ready=0; two back-to-back good frames 0x11 then 0x22.
  - Response: dout=0x11 held, overrun pulses at the second stop edge; raising dout_ready clears dout_valid and dout stays 0x11.
- Simultaneous accept and commit.
  - Stimulus: dout_valid=1 holding 0x11; dout_ready=1 on exactly the stop edge of a 0x22 frame.
  - Response: dout=0x22, dout_valid remains 1, no overrun.
- Strobe gating and reset.
  - Stimulus: bit_en high every 4th clk with frame 0xF0; then assert reset for one clk after the 4th data bit of another frame.
  - Response: first frame gives dout=0xF0. After reset: busy=0, dout_valid=0, no error pulses, and the rest of the aborted frame's bits (all 1s) do not start a new frame.
- With SISO_RX_PARITY_EN.
  - Stimulus: data 0x07 with parity bit 0 (expected 1), good stop bit.
  - Response: parity_err pulses, dout=0x07 with dout_valid=1.

Source files
------------

// File: rtl/siso_rx_pkg.sv
// Shared types and line levels for the serial frame receiver.
package siso_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } rx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Even parity over up to 32 data bits; zero padding does not change the result.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/siso_frame_rx_if.sv
// Serial-in / parallel-out bus of the frame receiver.
interface siso_frame_rx_if #(
  parameter int unsigned W = 8
);
  logic         si;
  logic         bit_en;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         busy;
  logic         frame_err;
  logic         overrun;
  logic         parity_err;

  modport slave (
    input  si, bit_en, dout_ready,
    output dout, dout_valid, busy, frame_err, overrun, parity_err
  );

  modport master (
    output si, bit_en, dout_ready,
    input  dout, dout_valid, busy, frame_err, overrun, parity_err
  );
endinterface

// File: rtl/siso_rx_hold.sv
// Output holding register: accepts completed words, handles the valid/ready
// handshake and flags words dropped while the register is still occupied.
module siso_rx_hold #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_commit,
  input  logic [W-1:0] i_word,
  input  logic         i_dout_ready,
  output logic [W-1:0] o_dout,
  output logic         o_dout_valid,
  output logic         o_overrun
);

  logic [W-1:0] r_dout;
  logic         r_dout_valid;
  logic         r_overrun;
  logic         w_free;

  assign w_free = !r_dout_valid || i_dout_ready;

  // A commit on the accept edge wins: the new word replaces the consumed one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (i_commit && w_free) begin
        r_dout       <= i_word;
        r_dout_valid <= 1'b1;
      end else if (i_commit) begin
        r_overrun <= 1'b1;
      end else if (r_dout_valid && i_dout_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_overrun    = r_overrun;

endmodule

// File: rtl/siso_frame_rx.sv
// Serial frame receiver: start bit, W data bits MSB-first, optional even
// parity (SISO_RX_PARITY_EN), stop bit; words leave through siso_rx_hold.
module siso_frame_rx
  import siso_rx_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input logic            clk,
  input logic            reset,
  siso_frame_rx_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(W + 1);

  rx_state_t    r_state, w_state_nxt;
  logic [W-1:0] r_shreg, w_shreg_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic         r_frame_err, w_frame_err_nxt;
  logic         r_busy;
  logic         w_commit;
  logic [W-1:0] w_dout;
  logic         w_dout_valid;
  logic         w_overrun;
`ifdef SISO_RX_PARITY_EN
  logic         r_par_bit, w_par_bit_nxt;
  logic         r_parity_err, w_parity_err_nxt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SISO_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_shreg     <= w_shreg_nxt;
      r_cnt       <= w_cnt_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_busy      <= (w_state_nxt != IDLE);
`ifdef SISO_RX_PARITY_EN
      r_par_bit    <= w_par_bit_nxt;
      r_parity_err <= w_parity_err_nxt;
`endif
    end
  end

  // Next-state logic; everything holds unless bit_en strobes a sample.
  always_comb begin
    w_state_nxt     = r_state;
    w_shreg_nxt     = r_shreg;
    w_cnt_nxt       = r_cnt;
    w_frame_err_nxt = 1'b0;
    w_commit        = 1'b0;
`ifdef SISO_RX_PARITY_EN
    w_par_bit_nxt    = r_par_bit;
    w_parity_err_nxt = 1'b0;
`endif
    if (bus.bit_en) begin
      unique case (r_state)
        IDLE: begin
          if (bus.si == START_LEVEL) begin
            w_state_nxt = DATA;
            w_cnt_nxt   = '0;
          end
        end
        DATA: begin
          w_shreg_nxt = {r_shreg[W-2:0], bus.si};
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(W - 1)) begin
`ifdef SISO_RX_PARITY_EN
            w_state_nxt = PAR;
`else
            w_state_nxt = STOP;
`endif
          end
        end
`ifdef SISO_RX_PARITY_EN
        PAR: begin
          w_par_bit_nxt = bus.si;
          w_state_nxt   = STOP;
        end
`endif
        STOP: begin
          w_state_nxt = IDLE;
          if (bus.si == IDLE_LEVEL) w_commit = 1'b1;
          else                      w_frame_err_nxt = 1'b1;
`ifdef SISO_RX_PARITY_EN
          w_parity_err_nxt = (r_par_bit != even_parity(32'(r_shreg)));
`endif
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  siso_rx_hold #(.W(W)) u_hold (
    .clk          (clk),
    .reset        (reset),
    .i_commit     (w_commit),
    .i_word       (r_shreg),
    .i_dout_ready (bus.dout_ready),
    .o_dout       (w_dout),
    .o_dout_valid (w_dout_valid),
    .o_overrun    (w_overrun)
  );

  assign bus.dout       = w_dout;
  assign bus.dout_valid = w_dout_valid;
  assign bus.overrun    = w_overrun;
  assign bus.busy       = r_busy;
  assign bus.frame_err  = r_frame_err;
`ifdef SISO_RX_PARITY_EN
  assign bus.parity_err = r_parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_siso_frame_rx.sv
// Directed bench for siso_frame_rx (W=8); covers SISO_RX_PARITY_EN when defined.
module tb_siso_frame_rx;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   n_ferr;
  int   n_ovr;
  int   n_perr;
`ifdef SISO_RX_PARITY_EN
  logic par_flip;
`endif

  siso_frame_rx_if #(.W(8)) bus ();

  siso_frame_rx #(.W(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tally sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.frame_err)  n_ferr <= n_ferr + 1;
      if (bus.overrun)    n_ovr  <= n_ovr + 1;
      if (bus.parity_err) n_perr <= n_perr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    bus.si     = b;
    bus.bit_en = 1'b1;
    tick();
    bus.bit_en = 1'b0;
    for (int i = 1; i < gap; i++) tick();
  endtask

  // Start bit, data MSB-first and (when built in) the parity bit.
  task automatic send_body(input logic [7:0] d, input int gap);
    send_bit(1'b0, gap);
    for (int i = 7; i >= 0; i--) send_bit(d[i], gap);
`ifdef SISO_RX_PARITY_EN
    send_bit((^d) ^ par_flip, gap);
`endif
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
    send_body(d, gap);
    send_bit(stop, gap);
  endtask

  task automatic idle_tick();
    bus.si     = 1'b1;
    bus.bit_en = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_ferr = 0; n_ovr = 0; n_perr = 0;
`ifdef SISO_RX_PARITY_EN
    par_flip = 1'b0;
`endif
    reset          = 1'b1;
    bus.si         = 1'b1;
    bus.bit_en     = 1'b0;
    bus.dout_ready = 1'b0;
    tick();
    tick();
    check("rst_busy",  32'(bus.busy),       32'h0);
    check("rst_valid", 32'(bus.dout_valid), 32'h0);
    check("rst_dout",  32'(bus.dout),       32'h0);
    check("rst_ferr",  32'(bus.frame_err),  32'h0);
    check("rst_ovr",   32'(bus.overrun),    32'h0);
    reset = 1'b0;
    idle_tick();

    // Basic frame 0xA5
    bus.dout_ready = 1'b1;
    send_body(8'hA5, 1);
    check("a5_busy", 32'(bus.busy), 32'h1);
    send_bit(1'b1, 1);
    check("a5_dout",  32'(bus.dout),       32'hA5);
    check("a5_valid", 32'(bus.dout_valid), 32'h1);
    check("a5_ferr",  32'(bus.frame_err),  32'h0);
    idle_tick();
    check("a5_valid_clr", 32'(bus.dout_valid), 32'h0);

    // Framing error then recovery
    send_frame(8'h3C, 1'b0, 1);
    check("fe_pulse", 32'(bus.frame_err),  32'h1);
    check("fe_valid", 32'(bus.dout_valid), 32'h0);
    idle_tick();
    check("fe_pulse_end", 32'(bus.frame_err), 32'h0);
    send_frame(8'h81, 1'b1, 1);
    check("fe_next_dout",  32'(bus.dout),       32'h81);
    check("fe_next_valid", 32'(bus.dout_valid), 32'h1);
    idle_tick();

    // Backpressure and overrun
    bus.dout_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1);
    check("bp_first", 32'(bus.dout), 32'h11);
    send_frame(8'h22, 1'b1, 1);
    check("bp_ovr",   32'(bus.overrun),    32'h1);
    check("bp_hold",  32'(bus.dout),       32'h11);
    check("bp_valid", 32'(bus.dout_valid), 32'h1);
    idle_tick();
    check("bp_ovr_end", 32'(bus.overrun), 32'h0);
    bus.dout_ready = 1'b1;
    idle_tick();
    check("bp_acc_valid", 32'(bus.dout_valid), 32'h0);
    check("bp_acc_dout",  32'(bus.dout),       32'h11);
    bus.dout_ready = 1'b0;

    // Accept and commit on the same edge
    send_frame(8'h11, 1'b1, 1);
    send_body(8'h22, 1);
    bus.dout_ready = 1'b1;
    send_bit(1'b1, 1);
    check("sim_dout",  32'(bus.dout),       32'h22);
    check("sim_valid", 32'(bus.dout_valid), 32'h1);
    check("sim_ovr",   32'(bus.overrun),    32'h0);
    idle_tick();
    check("sim_clr", 32'(bus.dout_valid), 32'h0);
    bus.dout_ready = 1'b0;

    // Strobe every 4th clk
    send_frame(8'hF0, 1'b1, 4);
    check("gap_dout",  32'(bus.dout),       32'hF0);
    check("gap_valid", 32'(bus.dout_valid), 32'h1);

    // Reset after 4 data bits of 0x5F
    send_bit(1'b0, 4);
    send_bit(1'b0, 4);
    send_bit(1'b1, 4);
    send_bit(1'b0, 4);
    send_bit(1'b1, 4);
    check("ab_busy_pre", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ab_busy",  32'(bus.busy),       32'h0);
    check("ab_valid", 32'(bus.dout_valid), 32'h0);
    check("ab_dout",  32'(bus.dout),       32'h0);
    for (int i = 0; i < 6; i++) send_bit(1'b1, 4);
    check("ab_idle", 32'(bus.busy),       32'h0);
    check("ab_nocm", 32'(bus.dout_valid), 32'h0);
    bus.dout_ready = 1'b1;

`ifdef SISO_RX_PARITY_EN
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 1);
    check("par_err",   32'(bus.parity_err), 32'h1);
    check("par_dout",  32'(bus.dout),       32'h07);
    check("par_valid", 32'(bus.dout_valid), 32'h1);
    par_flip = 1'b0;
    idle_tick();
    send_frame(8'h03, 1'b1, 1);
    check("par_ok", 32'(bus.parity_err), 32'h0);
    idle_tick();
`endif

    idle_tick();
    check("cnt_ferr", 32'(n_ferr), 32'd1);
    check("cnt_ovr",  32'(n_ovr),  32'd1);
`ifdef SISO_RX_PARITY_EN
    check("cnt_perr", 32'(n_perr), 32'd1);
`else
    check("cnt_perr", 32'(n_perr), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
